// File: rtl/uart_hex_dump.sv
// Formats accepted words as ASCII hex text for a byte-wide UART transmitter.
// An optional "0x" prefix, the hex digits MSB first, then a separator or CR LF.
module uart_hex_dump #(
  parameter int          DATA_W         = 8,
  parameter int          WORDS_PER_LINE = 16,
  parameter logic [7:0]  SEP_CHAR       = 8'h20,
  parameter bit          PREFIX_EN      = 1'b0,
  parameter bit          UPPERCASE      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_busy,
  output logic [7:0]        col
);

  localparam logic [3:0] PFX = PREFIX_EN ? 4'd2 : 4'd0;
  localparam logic [3:0] D   = 4'(DATA_W / 4);

  typedef enum logic [1:0] {IDLE, EMIT, ACK, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] word, word_sh;
  logic [3:0]        idx, n_chars, pos, nib;
  logic              flush_seq, crlf;
  logic              accept, flush_go, fire, last, col_hit;
  logic [7:0]        cur_char;

  function automatic logic [7:0] hex(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, v};
  endfunction

  // The line-ending decision is made once, at accept, from the column count.
  assign col_hit = (WORDS_PER_LINE != 0) && (({1'b0, col} + 9'd1) == 9'(WORDS_PER_LINE));
  assign n_chars = flush_seq ? 4'd2 : PFX + D + (crlf ? 4'd2 : 4'd1);
  assign last    = (idx == n_chars - 4'd1);
  assign pos     = idx - PFX;
  assign nib     = D - 4'd1 - pos;
  assign word_sh = word >> {nib, 2'b00};

  always_comb begin
    cur_char = SEP_CHAR;
    if (flush_seq)                      cur_char = (idx == 4'd0) ? 8'h0D : 8'h0A;
    else if (PREFIX_EN && idx < 4'd2)   cur_char = (idx == 4'd0) ? 8'h30 : 8'h78;
    else if (pos < D)                   cur_char = hex(word_sh[3:0]);
    else if (crlf)                      cur_char = (pos == D) ? 8'h0D : 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept || flush_go) state_nxt = EMIT;
      EMIT:    if (!tx_busy)           state_nxt = ACK;
      ACK:     if (tx_busy)            state_nxt = DRAIN;
      DRAIN:   if (!tx_busy)           state_nxt = last ? IDLE : EMIT;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_ready && in_valid;
    flush_go = in_ready && !in_valid && flush && (col != 8'd0) && (WORDS_PER_LINE != 0);
    fire     = (state == EMIT) && !tx_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word      <= '0;
      idx       <= '0;
      flush_seq <= 1'b0;
      crlf      <= 1'b0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      col       <= '0;
    end else begin
      tx_en <= fire;
      if (accept) begin
        word      <= in_data;
        idx       <= '0;
        flush_seq <= 1'b0;
        crlf      <= col_hit;
      end else if (flush_go) begin
        idx       <= '0;
        flush_seq <= 1'b1;
      end
      // Column advances on the last character of a word; any CR LF restarts the line.
      if (fire) begin
        tx_data <= cur_char;
        if (last) col <= (flush_seq || crlf) ? 8'd0 : col + 8'd1;
      end
      if (state == DRAIN && !tx_busy && !last) idx <= idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_uart_hex_dump.sv
// Directed bench for uart_hex_dump: three configurations, each driving a behavioural uart_tx.
module tb_uart_hex_dump;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111, in_valid = 3'b000, flush = 3'b000;
  logic [2:0]  in_ready, tx_en, tx_busy;
  logic [7:0]  da = 8'h00, dc = 8'h00;
  logic [15:0] db = 16'h0000;
  logic [7:0]  tx_data [3];
  logic [7:0]  col [3];

  int          cnt [3]     = '{0, 0, 0};
  int          log_n [3]   = '{0, 0, 0};
  int          viol [3]    = '{0, 0, 0};
  logic [2:0]  en_prev     = 3'b000;
  logic [7:0]  log_mem [3][64];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // u_a: defaults, u_b: 16-bit lowercase with prefix, u_c: two words per line
  uart_hex_dump u_a (.clk(clk), .rst(rst[0]), .in_data(da), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .tx_data(tx_data[0]), .tx_en(tx_en[0]),
    .tx_busy(tx_busy[0]), .col(col[0]));
  uart_hex_dump #(.DATA_W(16), .PREFIX_EN(1'b1), .UPPERCASE(1'b0)) u_b (.clk(clk),
    .rst(rst[1]), .in_data(db), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .flush(flush[1]), .tx_data(tx_data[1]), .tx_en(tx_en[1]), .tx_busy(tx_busy[1]),
    .col(col[1]));
  uart_hex_dump #(.WORDS_PER_LINE(2)) u_c (.clk(clk), .rst(rst[2]), .in_data(dc),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .flush(flush[2]), .tx_data(tx_data[2]),
    .tx_en(tx_en[2]), .tx_busy(tx_busy[2]), .col(col[2]));

  // uart_tx stand-in: busy rises the cycle after tx_en and stays high for 20 cycles
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (tx_en[g]) begin
        cnt[g] <= 20;
        log_mem[g][6'(log_n[g])] <= tx_data[g];
        log_n[g] <= log_n[g] + 1;
        if (tx_busy[g] || en_prev[g]) viol[g] <= viol[g] + 1;
      end else if (cnt[g] != 0) begin
        cnt[g] <= cnt[g] - 1;
      end
      en_prev[g] <= tx_en[g];
    end
  end

  always_comb for (int g = 0; g < 3; g++) tx_busy[g] = (cnt[g] != 0);

  task automatic drive(input int g, input logic [15:0] d);
    case (g)
      0:       da = d[7:0];
      1:       db = d;
      default: dc = d[7:0];
    endcase
  endtask

  task automatic send(input int g, input logic [15:0] d);
    drive(g, d);
    in_valid[g] = 1'b1;
    @(negedge clk);
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready[g]) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_chars(input int g, input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (log_n[g] >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (in_ready[g] !== 1'b1 || tx_en[g] !== 1'b0 || tx_data[g] !== 8'h00 || col[g] !== 8'h00)
        $display("FAIL reset[%0d] got rdy=%b en=%b data=%h col=%h want rdy=1 en=0 data=00 col=00",
                 g, in_ready[g], tx_en[g], tx_data[g], col[g]);
      else passed++;
    end
    rst = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] e [3] = '{8'h41, 8'h35, 8'h20};
    int s = log_n[0];
    bit to;
    send(0, 16'h00A5);
    da = 8'h00;
    checks++;
    if (in_ready[0] !== 1'b0 || tx_en[0] !== 1'b0)
      $display("FAIL basic_accept got rdy=%b en=%b want rdy=0 en=0", in_ready[0], tx_en[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (tx_en[0] !== 1'b1 || tx_data[0] !== 8'h41)
      $display("FAIL basic_latency got en=%b data=%h want en=1 data=41", tx_en[0], tx_data[0]);
    else passed++;
    wait_idle(0, to);
    checks++;
    if (to !== 1'b0 || log_n[0] - s !== 3 || tx_busy[0] !== 1'b0)
      $display("FAIL basic_ready_rise got timeout=%b chars=%0d busy=%b want 0 3 0",
               to, log_n[0] - s, tx_busy[0]);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_mem[0][6'(s + i)] !== e[i])
        $display("FAIL basic_char%0d got %h want %h", i, log_mem[0][6'(s + i)], e[i]);
      else passed++;
    end
    checks++;
    if (col[0] !== 8'd1) $display("FAIL basic_col got %0d want 1", col[0]);
    else passed++;
  endtask

  task automatic test_prefix();
    logic [7:0] e [7] = '{8'h30, 8'h78, 8'h62, 8'h65, 8'h65, 8'h66, 8'h20};
    int s = log_n[1];
    bit to;
    send(1, 16'hBEEF);
    wait_idle(1, to);
    checks++;
    if (to !== 1'b0 || log_n[1] - s !== 7)
      $display("FAIL prefix_len got timeout=%b chars=%0d want 0 7", to, log_n[1] - s);
    else passed++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (log_mem[1][6'(s + i)] !== e[i])
        $display("FAIL prefix_char%0d got %h want %h", i, log_mem[1][6'(s + i)], e[i]);
      else passed++;
    end
    checks++;
    if (col[1] !== 8'd1) $display("FAIL prefix_col got %0d want 1", col[1]);
    else passed++;
  endtask

  task automatic test_line_wrap();
    logic [7:0] e [10] = '{8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h0D, 8'h0A, 8'h30, 8'h33, 8'h20};
    logic [7:0] ec [3] = '{8'd1, 8'd0, 8'd1};
    int s = log_n[2];
    bit to;
    for (int w = 0; w < 3; w++) begin
      send(2, 16'(w + 1));
      wait_idle(2, to);
      checks++;
      if (to !== 1'b0 || col[2] !== ec[w])
        $display("FAIL wrap_col%0d got timeout=%b col=%0d want 0 %0d", w, to, col[2], ec[w]);
      else passed++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_mem[2][6'(s + i)] !== e[i])
        $display("FAIL wrap_char%0d got %h want %h", i, log_mem[2][6'(s + i)], e[i]);
      else passed++;
    end
  endtask

  task automatic test_flush();
    int s = log_n[2];
    bit to;
    flush[2] = 1'b1;
    wait_chars(2, s + 2, to);
    if (!to) wait_idle(2, to);
    checks++;
    if (to !== 1'b0 || log_mem[2][6'(s)] !== 8'h0D || log_mem[2][6'(s + 1)] !== 8'h0A || col[2] !== 8'd0)
      $display("FAIL flush_crlf got timeout=%b %h %h col=%0d want 0 0d 0a 0", to,
               log_mem[2][6'(s)], log_mem[2][6'(s + 1)], col[2]);
    else passed++;
    repeat (60) @(negedge clk);
    checks++;
    if (log_n[2] - s !== 2 || in_ready[2] !== 1'b1)
      $display("FAIL flush_hold got chars=%0d rdy=%b want 2 1", log_n[2] - s, in_ready[2]);
    else passed++;
    flush[2] = 1'b0;
  endtask

  task automatic test_valid_flush();
    logic [7:0] e [5] = '{8'h33, 8'h43, 8'h20, 8'h0D, 8'h0A};
    int s = log_n[0];
    bit to;
    flush[0] = 1'b1;
    send(0, 16'h003C);
    wait_chars(0, s + 5, to);
    if (!to) wait_idle(0, to);
    checks++;
    if (to !== 1'b0 || col[0] !== 8'd0)
      $display("FAIL vflush_done got timeout=%b col=%0d want 0 0", to, col[0]);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_mem[0][6'(s + i)] !== e[i])
        $display("FAIL vflush_char%0d got %h want %h", i, log_mem[0][6'(s + i)], e[i]);
      else passed++;
    end
    repeat (40) @(negedge clk);
    checks++;
    if (log_n[0] - s !== 5) $display("FAIL vflush_hold got chars=%0d want 5", log_n[0] - s);
    else passed++;
    flush[0] = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [7:0] e [3] = '{8'h31, 8'h30, 8'h20};
    int s = log_n[0];
    int pulses = 0;
    bit to;
    send(0, 16'h00FF);
    wait_chars(0, s + 2, to);
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (to !== 1'b0 || tx_en[0] !== 1'b0 || in_ready[0] !== 1'b1 || col[0] !== 8'd0 || tx_data[0] !== 8'h00)
      $display("FAIL abort_reset got timeout=%b en=%b rdy=%b col=%0d data=%h want 0 0 1 0 00",
               to, tx_en[0], in_ready[0], col[0], tx_data[0]);
    else passed++;
    rst[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_en[0]) pulses++;
    end
    checks++;
    if (pulses !== 0 || log_n[0] - s !== 2)
      $display("FAIL abort_quiet got pulses=%0d chars=%0d want 0 2", pulses, log_n[0] - s);
    else passed++;
    send(0, 16'h0010);
    wait_idle(0, to);
    checks++;
    if (to !== 1'b0 || log_n[0] - s !== 5 || col[0] !== 8'd1)
      $display("FAIL abort_next got timeout=%b chars=%0d col=%0d want 0 5 1", to, log_n[0] - s, col[0]);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_mem[0][6'(s + 2 + i)] !== e[i])
        $display("FAIL abort_char%0d got %h want %h", i, log_mem[0][6'(s + 2 + i)], e[i]);
      else passed++;
    end
  endtask

  task automatic test_protocol();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (viol[g] !== 0)
        $display("FAIL protocol[%0d] got %0d bad tx_en pulses want 0", g, viol[g]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_line_wrap();
    test_flush();
    test_valid_flush();
    test_reset_abort();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
